// File: rtl/cpu_feeder_pkg.sv
// Shared types and constants for the cpu instruction feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cpu_feeder_pkg;

   localparam int DEF_IW = 32;

   localparam logic [1:0] MODE_RUN  = 2'd0;
   localparam logic [1:0] MODE_STEP = 2'd1;
   localparam logic [1:0] MODE_LOOP = 2'd2;
   localparam logic [1:0] MODE_ILL  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_RDY,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_STEP_WAIT
   } state_e;

endpackage

// File: rtl/feeder_prog_ram.sv
// Program buffer: DEPTH x IW simple dual-port RAM, one write port, one read port.
// Latency: read data valid the cycle after re is sampled; writes land on the edge.
// Backpressure: none; accepts a write and a read every cycle.
module feeder_prog_ram #(
   parameter int IW    = 32,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);

   logic [IW-1:0] mem_q [DEPTH];
   logic [IW-1:0] rdata_q;

   // Write port: contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   // Registered read, only when the sequencer asks for a word.
   always_ff @(posedge clk) begin
      if (re) rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/cpu_inst_feeder.sv
// Sequencer that issues a loaded program to the cpu over the up/st handshake.
// Latency: start at edge N gives sys_inst_up during cycle N+3 when st is already high.
// Backpressure: waits on sys_inst_st before each issue; times out after ACK_TIMEOUT cycles.
module cpu_inst_feeder
   import cpu_feeder_pkg::*;
#(
   parameter int IW          = DEF_IW,
   parameter int DEPTH       = 16,
   parameter int AW          = $clog2(DEPTH),
   parameter int ACK_TIMEOUT = 64
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic          sys_prog_we,
   input  logic [AW-1:0] sys_prog_addr,
   input  logic [IW-1:0] sys_prog_data,
   input  logic          sys_run_start,
   input  logic          sys_run_stop,
   input  logic [1:0]    sys_run_mode,
   input  logic [AW:0]   sys_run_len,
   input  logic          sys_step,
   output logic [IW-1:0] sys_inst_cmd,
   output logic          sys_inst_up,
   input  logic          sys_inst_st,
   output logic          sys_busy,
   output logic          sys_done,
   output logic          sys_err,
   output logic [AW-1:0] sys_pc,
   output logic [31:0]   sys_issued_cnt
);

   localparam int            TW       = $clog2(ACK_TIMEOUT + 1);
   localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);
   // The ISSUE cycle counts as the first waited cycle, so the timer starts at 1.
   localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW:0]   len_q, len_d;
   logic [1:0]    mode_q, mode_d;
   logic [IW-1:0] cmd_q, cmd_d;
   logic          err_q, err_d;
   logic          done_q, done_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          stop_pend_q, stop_pend_d;

   logic          ram_we;
   logic          ram_re;
   logic [IW-1:0] ram_rdata;
   logic [AW:0]   pc_inc;

   assign pc_inc = {1'b0, pc_q} + (AW+1)'(1);
   assign ram_we = sys_prog_we && (state_q == ST_IDLE);
   assign ram_re = (state_q == ST_FETCH);

   feeder_prog_ram #(
      .IW    (IW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_prog_ram (
      .clk   (sys_clk),
      .we    (ram_we),
      .waddr (sys_prog_addr),
      .wdata (sys_prog_data),
      .re    (ram_re),
      .raddr (pc_q),
      .rdata (ram_rdata)
   );

   // Next-state, handshake and bookkeeping for the issue sequence.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      len_d       = len_q;
      mode_d      = mode_q;
      cmd_d       = cmd_q;
      err_d       = err_q;
      done_d      = 1'b0;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      stop_pend_d = stop_pend_q;

      // Program must not change under a running sequence.
      if (sys_prog_we && (state_q != ST_IDLE)) err_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            stop_pend_d = 1'b0;
            if (sys_run_start && !sys_run_stop) begin
               if ((sys_run_mode == MODE_ILL) || (sys_run_len == '0) || (sys_run_len > LEN_MAX)) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_FETCH;
                  pc_d    = '0;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  len_d   = sys_run_len;
                  mode_d  = sys_run_mode;
               end
            end
         end
         ST_FETCH: begin
            if (sys_run_stop) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_WAIT_RDY;
            end
         end
         ST_WAIT_RDY: begin
            if (sys_run_stop) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (sys_inst_st) begin
               state_d = ST_ISSUE;
               cmd_d   = ram_rdata;
            end
         end
         ST_ISSUE: begin
            if (sys_run_stop) stop_pend_d = 1'b1;
            tmo_d   = TW'(1);
            state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (sys_run_stop) stop_pend_d = 1'b1;
            if (!sys_inst_st) begin
               if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
               if (stop_pend_q || sys_run_stop) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else if (pc_inc < len_q) begin
                  pc_d    = pc_q + AW'(1);
                  state_d = (mode_q == MODE_STEP) ? ST_STEP_WAIT : ST_FETCH;
               end else if (mode_q == MODE_LOOP) begin
                  pc_d    = '0;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_STEP_WAIT: begin
            if (sys_run_stop) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (sys_step) begin
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset clears every output-facing flop.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         len_q       <= '0;
         mode_q      <= '0;
         cmd_q       <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         len_q       <= len_d;
         mode_q      <= mode_d;
         cmd_q       <= cmd_d;
         err_q       <= err_d;
         done_q      <= done_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         stop_pend_q <= stop_pend_d;
      end
   end

   assign sys_inst_cmd   = cmd_q;
   assign sys_inst_up    = (state_q == ST_ISSUE);
   assign sys_busy       = (state_q != ST_IDLE);
   assign sys_done       = done_q;
   assign sys_err        = err_q;
   assign sys_pc         = pc_q;
   assign sys_issued_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_inst_feeder.sv
// Self-checking bench for cpu_inst_feeder with a stub cpu and a command scoreboard.
// Latency: checks start-to-up and up-to-timeout spacing explicitly.
// Backpressure: stub cpu acknowledges after a programmable delay or never.
module tb_cpu_inst_feeder;
   import cpu_feeder_pkg::*;

   localparam int IW    = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int TMO   = 8;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic          sys_prog_we = 1'b0;
   logic [AW-1:0] sys_prog_addr = '0;
   logic [IW-1:0] sys_prog_data = '0;
   logic          sys_run_start = 1'b0;
   logic          sys_run_stop = 1'b0;
   logic [1:0]    sys_run_mode = '0;
   logic [AW:0]   sys_run_len = '0;
   logic          sys_step = 1'b0;
   logic [IW-1:0] sys_inst_cmd;
   logic          sys_inst_up;
   logic          sys_inst_st = 1'b1;
   logic          sys_busy;
   logic          sys_done;
   logic          sys_err;
   logic [AW-1:0] sys_pc;
   logic [31:0]   sys_issued_cnt;

   always #5 sys_clk = ~sys_clk;

   cpu_inst_feeder #(
      .IW          (IW),
      .DEPTH       (DEPTH),
      .AW          (AW),
      .ACK_TIMEOUT (TMO)
   ) dut (
      .sys_clk        (sys_clk),
      .sys_rst        (sys_rst),
      .sys_prog_we    (sys_prog_we),
      .sys_prog_addr  (sys_prog_addr),
      .sys_prog_data  (sys_prog_data),
      .sys_run_start  (sys_run_start),
      .sys_run_stop   (sys_run_stop),
      .sys_run_mode   (sys_run_mode),
      .sys_run_len    (sys_run_len),
      .sys_step       (sys_step),
      .sys_inst_cmd   (sys_inst_cmd),
      .sys_inst_up    (sys_inst_up),
      .sys_inst_st    (sys_inst_st),
      .sys_busy       (sys_busy),
      .sys_done       (sys_done),
      .sys_err        (sys_err),
      .sys_pc         (sys_pc),
      .sys_issued_cnt (sys_issued_cnt)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Scoreboard and bench-side copy of the program buffer.
   logic [IW-1:0] exp_q [$];
   logic [IW-1:0] prog [DEPTH];
   int up_cnt  = 0;
   int ack_cnt = 0;
   int ack_dly = 0;
   bit hang    = 1'b0;

   // Stub cpu: pops the expected command on every up, drops st after ack_dly+1 cycles.
   int stub_cnt  = 0;
   bit stub_pend = 1'b0;
   bit stub_low  = 1'b0;
   always @(negedge sys_clk) begin
      if (sys_rst) begin
         sys_inst_st = 1'b1;
         stub_pend   = 1'b0;
         stub_low    = 1'b0;
      end else begin
         if (stub_low) begin
            sys_inst_st = 1'b1;
            stub_low    = 1'b0;
         end else if (stub_pend) begin
            if (stub_cnt == 0) begin
               sys_inst_st = 1'b0;
               stub_pend   = 1'b0;
               stub_low    = 1'b1;
               ack_cnt++;
            end else begin
               stub_cnt--;
            end
         end
         if (sys_inst_up) begin
            up_cnt++;
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL up_unexpected: cmd 0x%0h issued, scoreboard empty", sys_inst_cmd);
            end else begin
               check("up_cmd", sys_inst_cmd, exp_q.pop_front());
            end
            if (!hang) begin
               stub_pend = 1'b1;
               stub_cnt  = ack_dly;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic write_prog(input int a, input logic [IW-1:0] d);
      sys_prog_we   = 1'b1;
      sys_prog_addr = AW'(a);
      sys_prog_data = d;
      @(negedge sys_clk);
      sys_prog_we   = 1'b0;
   endtask

   task automatic pulse_start(input logic [1:0] m, input logic [AW:0] l);
      sys_run_mode  = m;
      sys_run_len   = l;
      sys_run_start = 1'b1;
      @(negedge sys_clk);
      sys_run_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge sys_clk);
         if (sys_done) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_up(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge sys_clk);
         if (sys_inst_up) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [AW:0] len;
      bit          exp_err;
      int          exp_issued;
   } vec_t;

   vec_t vecs [7];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      bit seen;
      int up0, lat, done_k;

      vecs[0] = '{MODE_RUN, 5'd3,  1'b0, 3};
      vecs[1] = '{MODE_RUN, 5'd1,  1'b0, 1};
      vecs[2] = '{MODE_RUN, 5'd16, 1'b0, 16};
      vecs[3] = '{MODE_RUN, 5'd0,  1'b1, 0};
      vecs[4] = '{MODE_ILL, 5'd2,  1'b1, 0};
      vecs[5] = '{MODE_RUN, 5'd17, 1'b1, 0};
      vecs[6] = '{MODE_RUN, 5'd2,  1'b0, 2};

      // Reset state.
      tick(3);
      check("rst_up", sys_inst_up, 0);
      check("rst_cmd", sys_inst_cmd, 0);
      check("rst_busy", sys_busy, 0);
      check("rst_done", sys_done, 0);
      check("rst_err", sys_err, 0);
      check("rst_pc", sys_pc, 0);
      check("rst_cnt", sys_issued_cnt, 0);
      sys_rst = 1'b0;
      tick(1);

      for (int i = 0; i < DEPTH; i++) prog[i] = 32'hC000_0000 | i;
      prog[0] = 32'h1200_0011;
      prog[1] = 32'h2080_0000;
      prog[2] = 32'h2042_0000;
      for (int i = 0; i < DEPTH; i++) write_prog(i, prog[i]);

      // Minimum start-to-up latency and done spacing for a single instruction.
      ack_dly = 0;
      exp_q.push_back(prog[0]);
      sys_run_mode  = MODE_RUN;
      sys_run_len   = 5'd1;
      sys_run_start = 1'b1;
      lat    = 0;
      done_k = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge sys_clk);
         sys_run_start = 1'b0;
         if (sys_inst_up && lat == 0) lat = k;
         if (sys_done && done_k == 0) done_k = k;
      end
      check("start_to_up_latency", lat, 3);
      check("up_to_done_latency", done_k, 5);

      // Table of run-once and illegal starts.
      for (int v = 0; v < 7; v++) begin
         up0 = up_cnt;
         if (!vecs[v].exp_err)
            for (int i = 0; i < int'(vecs[v].len); i++) exp_q.push_back(prog[i]);
         pulse_start(vecs[v].mode, vecs[v].len);
         if (!vecs[v].exp_err) begin
            wait_done(400, seen);
            check($sformatf("v%0d_done_seen", v), seen, 1);
            check($sformatf("v%0d_issued", v), sys_issued_cnt, vecs[v].exp_issued);
         end else begin
            tick(10);
         end
         check($sformatf("v%0d_err", v), sys_err, vecs[v].exp_err);
         check($sformatf("v%0d_busy", v), sys_busy, 0);
         check($sformatf("v%0d_ups", v), up_cnt - up0, vecs[v].exp_issued);
         check($sformatf("v%0d_sb_empty", v), exp_q.size(), 0);
      end

      // Start together with stop: nothing starts.
      up0 = up_cnt;
      sys_run_mode  = MODE_RUN;
      sys_run_len   = 5'd2;
      sys_run_start = 1'b1;
      sys_run_stop  = 1'b1;
      @(negedge sys_clk);
      sys_run_start = 1'b0;
      sys_run_stop  = 1'b0;
      tick(8);
      check("startstop_busy", sys_busy, 0);
      check("startstop_ups", up_cnt - up0, 0);

      // Step mode: a step during WAIT_ACK is dropped; program write while busy flags err.
      ack_dly = 3;
      up0 = up_cnt;
      exp_q.push_back(prog[0]);
      exp_q.push_back(prog[1]);
      pulse_start(MODE_STEP, 5'd2);
      wait_up(50, seen);
      check("step_first_up", seen, 1);
      @(negedge sys_clk);
      sys_step = 1'b1;
      @(negedge sys_clk);
      sys_step = 1'b0;
      tick(20);
      check("step_held_ups", up_cnt - up0, 1);
      check("step_held_busy", sys_busy, 1);
      check("step_held_pc", sys_pc, 1);
      write_prog(1, 32'hDEAD_BEEF);
      check("step_busy_write_err", sys_err, 1);
      sys_step = 1'b1;
      @(negedge sys_clk);
      sys_step = 1'b0;
      wait_done(50, seen);
      check("step_done_seen", seen, 1);
      check("step_issued", sys_issued_cnt, 2);
      check("step_ups", up_cnt - up0, 2);
      check("step_err_sticky", sys_err, 1);
      check("step_sb_empty", exp_q.size(), 0);

      // Loop mode: stop lands in WAIT_ACK of the 6th instruction, which still completes.
      ack_dly = 2;
      up0 = up_cnt;
      ack_cnt = 0;
      for (int i = 0; i < 8; i++) exp_q.push_back(prog[i % 2]);
      pulse_start(MODE_LOOP, 5'd2);
      check("loop_err_cleared", sys_err, 0);
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge sys_clk);
         if (ack_cnt >= 5) begin
            seen = 1'b1;
            break;
         end
      end
      check("loop_five_acks", seen, 1);
      wait_up(50, seen);
      check("loop_sixth_up", seen, 1);
      @(negedge sys_clk);
      sys_run_stop = 1'b1;
      @(negedge sys_clk);
      sys_run_stop = 1'b0;
      wait_done(50, seen);
      check("loop_done_seen", seen, 1);
      check("loop_issued", sys_issued_cnt, 6);
      check("loop_ups", up_cnt - up0, 6);
      check("loop_busy", sys_busy, 0);
      check("loop_sb_left", exp_q.size(), 2);
      exp_q.delete();

      // Acknowledge timeout: done exactly TMO cycles after the up pulse.
      hang = 1'b1;
      exp_q.push_back(prog[0]);
      pulse_start(MODE_RUN, 5'd1);
      wait_up(20, seen);
      check("tmo_up_seen", seen, 1);
      done_k = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge sys_clk);
         if (sys_done && done_k == 0) done_k = k;
      end
      check("tmo_done_delay", done_k, TMO);
      check("tmo_err", sys_err, 1);
      check("tmo_busy", sys_busy, 0);
      check("tmo_issued", sys_issued_cnt, 0);
      hang = 1'b0;

      // Reset during WAIT_ACK.
      ack_dly = 5;
      up0 = up_cnt;
      for (int i = 0; i < 3; i++) exp_q.push_back(prog[i]);
      pulse_start(MODE_RUN, 5'd3);
      wait_up(20, seen);
      check("rstmid_up_seen", seen, 1);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      check("rstmid_up", sys_inst_up, 0);
      check("rstmid_cmd", sys_inst_cmd, 0);
      check("rstmid_busy", sys_busy, 0);
      check("rstmid_pc", sys_pc, 0);
      check("rstmid_err", sys_err, 0);
      sys_rst = 1'b0;
      exp_q.delete();
      tick(3);
      check("rstmid_no_more_ups", up_cnt - up0, 1);

      // Fresh start with a simultaneous write to address 0: the new word is issued.
      ack_dly = 0;
      prog[0] = 32'h5A5A_0001;
      for (int i = 0; i < 3; i++) exp_q.push_back(prog[i]);
      sys_prog_we   = 1'b1;
      sys_prog_addr = '0;
      sys_prog_data = prog[0];
      pulse_start(MODE_RUN, 5'd3);
      sys_prog_we   = 1'b0;
      wait_done(100, seen);
      check("fresh_done_seen", seen, 1);
      check("fresh_issued", sys_issued_cnt, 3);
      check("fresh_err", sys_err, 0);
      check("fresh_sb_empty", exp_q.size(), 0);

      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cpu_inst_feeder.md
Name: cpu_inst_feeder

Overview:
Parametrised instruction sequencer that replaces bench-driven instruction injection in front of the cpu core. A host loads a program buffer of DEPTH words. On command, the block issues those words to the cpu over the sys_inst_cmd/sys_inst_up/sys_inst_st handshake. Supports run-once, single-step and loop modes, with acknowledge timeout, error flagging and issue counting. Sits between the test/system top and cpu, alongside mem.

Parameters:
IW, 32, instruction width (matches sys_inst_cmd)
DEPTH, 16, program buffer entries (power of two, >=2)
AW, $clog2(DEPTH), buffer address width
ACK_TIMEOUT, 64, max cycles to wait for sys_inst_st to fall after an up pulse

Ports:
sys_clk  in  1  clock
sys_rst  in  1  reset
sys_prog_we  in  1  program buffer write strobe
sys_prog_addr  in  AW  program write address
sys_prog_data  in  IW  program write data
sys_run_start  in  1  start pulse
sys_run_stop  in  1  stop request pulse
sys_run_mode  in  2  0=run-once, 1=step, 2=loop, 3=illegal
sys_run_len  in  AW+1  instruction count, 1..DEPTH
sys_step  in  1  step pulse (mode 1)
sys_inst_cmd  out  IW  instruction to cpu
sys_inst_up  out  1  issue strobe to cpu
sys_inst_st  in  1  cpu ready/idle
sys_busy  out  1  sequence active
sys_done  out  1  one-cycle end-of-sequence pulse
sys_err  out  1  sticky error
sys_pc  out  AW  index of next/current instruction
sys_issued_cnt  out  32  instructions acknowledged since last start

Behaviour:
- Interface: one clock sys_clk. sys_rst is synchronous, active-high.
- Reset: every output is 0. The state machine returns to IDLE. Buffer contents are undefined after reset.
- States: IDLE, FETCH, WAIT_RDY, ISSUE, WAIT_ACK, STEP_WAIT.
- IDLE:
  - start with len in 1..DEPTH and mode!=3 -> FETCH. On entry: pc=0, busy=1, issued_cnt=0, err cleared.
  - Illegal mode or len outside 1..DEPTH -> err=1, stay IDLE.
  - Start while busy is ignored.
- FETCH: synchronous buffer read at pc (1 cycle) -> WAIT_RDY.
- WAIT_RDY: wait for sys_inst_st==1 -> ISSUE.
- ISSUE: sys_inst_cmd <= fetched word; sys_inst_up=1 for exactly this one cycle -> WAIT_ACK.
- sys_inst_cmd holds its last issued value until the next ISSUE.
- WAIT_ACK:
  - sys_inst_st==0 -> issued_cnt++, then advance pc.
  - ACK_TIMEOUT cycles with st still high -> err=1, done pulse, busy=0 -> IDLE.
- Advance:
  - If pc+1 < len: pc++ and go to FETCH (modes 0, 2) or STEP_WAIT (mode 1).
  - If pc+1 == len, mode 0: done pulse, busy=0 -> IDLE.
  - If pc+1 == len, mode 2: pc wraps to 0 -> FETCH.
  - If pc+1 == len, mode 1: done pulse, busy=0 -> IDLE.
- STEP_WAIT: sys_step -> FETCH. Steps arriving in any other state are dropped.
- Latency: start at edge N gives up=1 during cycle N+3, provided st is already 1 (minimum).
- Stop:
  - Honoured only at instruction boundaries (FETCH, WAIT_RDY, STEP_WAIT) -> IDLE with done pulse. err is unchanged.
  - Stop during ISSUE or WAIT_ACK is latched and honoured once the acknowledge resolves.
  - Stop is the only exit from loop mode.
- Simultaneous events in IDLE:
  - start+stop: stop wins, nothing starts.
  - start+prog_we: the write lands first, and the following FETCH sees the new data.
- Program writes while busy are ignored and set err=1.
- issued_cnt saturates at 2^32-1.
- Reset mid-handshake: up drops in the same edge. The cpu sees no further strobe.

Decomposition:
- Package cpu_feeder_pkg: state enum, mode constants (MODE_RUN/MODE_STEP/MODE_LOOP), default IW.
- One sub-module: feeder_prog_ram, a DEPTH x IW simple dual-port RAM with synchronous read and one write port.

Test Plan:
- Load [0x12000011, 0x20800000, 0x20420000] at addr 0..2; mode 0, len 3, cpu+mem attached:
  - exactly 3 up pulses in that order;
  - reg0=17, reg1=17;
  - done pulse; issued_cnt=3; busy=0.
- Mode 1, len 2, same program: no second up until sys_step is pulsed; a step during WAIT_ACK has no effect; done follows the 2nd acknowledge.
- Mode 2, len 2, stop asserted after 5 acknowledges: up pulses alternate addr0/addr1; stop during WAIT_ACK completes that instruction; issued_cnt=5 or 6 at done, never mid-handshake.
- Stubbed cpu holding st=1 after up, ACK_TIMEOUT=8: err=1 and done exactly 8 cycles after the up pulse; busy=0.
- Start with len=0 and with mode=3: err=1, busy stays 0, no up pulse. Next legal start clears err.
- sys_rst asserted during WAIT_ACK: next edge up=0, cmd=0, busy=0, pc=0; a fresh start runs normally.
